regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the next-generation pipeline.
- Generalises the current single-write, two-read file to NUM_RD read ports and NUM_WR write ports, with configurable width and depth.
- Adds a per-register pending-write scoreboard: issue sets a busy bit, writeback clears it.
- Sits between decode (reads and issue) and writeback (commits).

Parameters:
- DATA_W, 32, register width in bits
- REG_NUM, 32, number of architectural registers; register 0 is hard-wired zero
- NUM_RD, 3, number of read ports
- NUM_WR, 2, number of write/commit ports
- ADDR_W, $clog2(REG_NUM), register index width (derived)

Ports:
- aclk  in  1  clock; all state updates on posedge
- areset  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read indices, port i in slice i
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  scoreboard busy bit of each read index, combinational
- wr_en  in  NUM_WR  write strobes
- wr_addr  in  NUM_WR*ADDR_W  write indices
- wr_data  in  NUM_WR*DATA_W  write data
- iss_en  in  1  issue strobe: mark iss_addr as pending
- iss_addr  in  ADDR_W  destination index being issued
- busy_vec  out  REG_NUM  full scoreboard, registered; bit 0 always 0

Behaviour:
- Reset (areset=1 at posedge): all registers become 0 and all busy bits 0.
  - Writes and issues in the reset cycle are ignored.
  - Reset mid-stream discards any pending scoreboard state.
  - After release, all outputs read 0 until the first write.
- Writes:
  - Write port w updates rf[wr_addr[w]] at the posedge when wr_en[w]=1 and wr_addr[w]!=0.
  - Address 0 is never written; its data is ignored.
- Write-write collision (same non-zero address, several enables in one cycle): the highest-numbered port wins.
- Read: rd_data[i] is 0 when rd_addr[i]==0; otherwise it is the array value, with bypass per Optional Feature.
- Scoreboard, evaluated each posedge:
  - busy[a] clears if any wr_en[w] targets a (a!=0).
  - busy[iss_addr] sets if iss_en=1 and iss_addr!=0.
  - Set and clear of the same index in one cycle: set wins (a new producer supersedes the retiring one).
  - Issue to an already-busy register keeps it busy; no counting.
  - A write to a non-busy register is legal and leaves busy at 0.
- rd_busy[i] = busy_vec[rd_addr[i]], taken from the registered vector.
  - No same-cycle bypass of iss_en or wr_en into rd_busy.
  - rd_busy is 0 for index 0.
- Latency:
  - Write visible on rd_data in the same cycle with bypass, or the next cycle without.
  - Scoreboard change visible the cycle after the strobe.
- Out-of-range indices (>= REG_NUM, when REG_NUM is not a power of two):
  - Reads return 0 and busy 0.
  - Writes and issues are dropped.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined:
  - rd_data[i] forwards wr_data from the same-cycle write matching rd_addr[i] (non-zero, enabled).
  - If several ports match, the highest-numbered port's data is forwarded, consistent with collision priority.
  - rd_busy is unchanged by bypass.
- Undefined:
  - rd_data[i] returns the pre-edge array contents; the write appears one cycle later.
  - The forwarding mux is absent.

Test Plan:
- Reset:
  - areset=1 for 2 cycles, then release; read all indices on all ports -> rd_data=0, busy_vec=0.
  - Same with wr_en[0]=1, wr_addr=5, wr_data=0xDEAD during reset -> rf[5] still 0 after release.
- r0 protection: wr_en[0]=1, wr_addr=0, wr_data=0xFFFFFFFF; iss_en=1, iss_addr=0 -> read of r0 returns 0; busy_vec[0]=0.
- Collision: port0 writes r7=0x11 and port1 writes r7=0x22 in the same cycle -> next cycle rd_data reads 0x22.
  - With REGFILE_MP_BYPASS_EN, a same-cycle read of r7 also returns 0x22.
- Bypass timing: write r3=0xABCD and read r3 in the same cycle.
  - With macro: returns 0xABCD that cycle.
  - Without macro: returns the old value (0) that cycle and 0xABCD the next.
- Scoreboard:
  - iss r9 at cycle t -> busy_vec[9]=1 and rd_busy=1 from t+1.
  - Write r9 at t+3 -> busy_vec[9]=0 from t+4.
  - Simultaneous iss r9 and write r9 -> busy_vec[9] stays 1.
- Reset mid-operation: busy r4 and r12 set, rf[4]=0x55; assert areset one cycle -> busy_vec=0, rf[4]=0 afterwards.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with a pending-write scoreboard; r0 is hard-wired zero.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32,
    parameter int NUM_RD  = 3,
    parameter int NUM_WR  = 2,
    parameter int ADDR_W  = $clog2(REG_NUM)
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [REG_NUM-1:0]       busy_vec
);

    localparam logic [ADDR_W:0] REG_LIM = (ADDR_W+1)'(REG_NUM);

    logic [DATA_W-1:0]  rf [REG_NUM];
    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] busy_next;

    // Index 0 and indices beyond the last register never touch state.
    function automatic logic idx_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && ({1'b0, a} < REG_LIM);
    endfunction

    // Later ports are assigned last, so the highest-numbered port wins a collision.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int r = 0; r < REG_NUM; r++) begin
                rf[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && idx_ok(wr_addr[w*ADDR_W +: ADDR_W])) begin
                    rf[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Clears are applied before the set so a new producer supersedes the retiring one.
    always_comb begin
        busy_next = busy;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && idx_ok(wr_addr[w*ADDR_W +: ADDR_W])) begin
                busy_next[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (iss_en && idx_ok(iss_addr)) begin
            busy_next[iss_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign busy_vec = busy;

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (idx_ok(rd_addr[i*ADDR_W +: ADDR_W])) begin
                rd_data[i*DATA_W +: DATA_W] = rf[rd_addr[i*ADDR_W +: ADDR_W]];
                rd_busy[i]                  = busy[rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_MP_BYPASS_EN
                for (int w = 0; w < NUM_WR; w++) begin
                    if (!areset && wr_en[w] &&
                        wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W]) begin
                        rd_data[i*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// checked against an array-based model of the register file and scoreboard.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int RN = 32;
    localparam int NR = 3;
    localparam int NW = 2;
    localparam int AW = 5;

    logic              aclk = 1'b0;
    logic              areset;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic [RN-1:0]     busy_vec;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] m_rf   [RN];
    logic          m_busy [RN];

    regfile_mp #(.DATA_W(DW), .REG_NUM(RN), .NUM_RD(NR), .NUM_WR(NW)) dut (
        .aclk(aclk), .areset(areset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec)
    );

    always #5 aclk = ~aclk;

    // Expected read value given the current stimulus and the pre-edge model state.
    function automatic logic [DW-1:0] exp_rd(input int a);
        if (a == 0) return '0;
`ifdef REGFILE_MP_BYPASS_EN
        if (!areset) begin
            for (int w = NW - 1; w >= 0; w--) begin
                if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) return wr_data[w*DW +: DW];
            end
        end
`endif
        return m_rf[a];
    endfunction

    function automatic logic [RN-1:0] exp_busy_vec();
        logic [RN-1:0] v;
        v = '0;
        for (int r = 1; r < RN; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic model_edge();
        int win;
        if (areset) begin
            for (int r = 0; r < RN; r++) begin
                m_rf[r]   = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int r = 1; r < RN; r++) begin
                win = -1;
                for (int w = 0; w < NW; w++) begin
                    if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == r) win = w;
                end
                if (win >= 0) begin
                    m_rf[r]   = wr_data[win*DW +: DW];
                    m_busy[r] = 1'b0;
                end
                if (iss_en && int'(iss_addr) == r) m_busy[r] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        areset   = 1'b0;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int p, input logic en, input int a, input logic [DW-1:0] d);
        wr_en[p]            = en;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic test_reset();
        logic [DW-1:0] e;
        idle();
        areset = 1'b1;
        set_wr(0, 1'b1, 5, 32'hDEAD);
        iss_en = 1'b1;
        iss_addr = 5'd5;
        tick();
        tick();
        idle();
        #2;
        for (int base = 0; base < RN; base += NR) begin
            for (int p = 0; p < NR; p++) set_rd(p, (base + p) % RN);
            #1;
            for (int p = 0; p < NR; p++) begin
                e = exp_rd((base + p) % RN);
                checks++;
                if (rd_data[p*DW +: DW] !== e || e !== '0) begin
                    failures++;
                    $display("[TB] FAIL reset_rd r%0d port%0d got=%h exp=%h", (base + p) % RN, p, rd_data[p*DW +: DW], e);
                end
                checks++;
                if (rd_busy[p] !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL reset_rd_busy r%0d got=%b exp=0", (base + p) % RN, rd_busy[p]);
                end
            end
        end
        checks++;
        if (busy_vec !== '0) begin
            failures++;
            $display("[TB] FAIL reset_busy_vec got=%h exp=0", busy_vec);
        end
    endtask

    task automatic test_r0();
        logic [DW-1:0] e;
        idle();
        set_wr(0, 1'b1, 0, 32'hFFFF_FFFF);
        iss_en = 1'b1;
        iss_addr = '0;
        set_rd(0, 0);
        #2;
        e = exp_rd(0);
        checks++;
        if (rd_data[0 +: DW] !== e) begin
            failures++;
            $display("[TB] FAIL r0_same_cycle got=%h exp=%h", rd_data[0 +: DW], e);
        end
        tick();
        idle();
        #2;
        checks++;
        if (rd_data[0 +: DW] !== 32'h0) begin
            failures++;
            $display("[TB] FAIL r0_read got=%h exp=0", rd_data[0 +: DW]);
        end
        checks++;
        if (busy_vec !== exp_busy_vec() || busy_vec[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL r0_busy got=%h exp=%h", busy_vec, exp_busy_vec());
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] e;
        idle();
        set_wr(0, 1'b1, 7, 32'h11);
        set_wr(1, 1'b1, 7, 32'h22);
        set_rd(0, 7);
        #2;
        e = exp_rd(7);
        checks++;
        if (rd_data[0 +: DW] !== e) begin
            failures++;
            $display("[TB] FAIL collision_same_cycle got=%h exp=%h", rd_data[0 +: DW], e);
        end
        tick();
        idle();
        set_rd(0, 7);
        #2;
        checks++;
        if (rd_data[0 +: DW] !== 32'h22) begin
            failures++;
            $display("[TB] FAIL collision_next got=%h exp=00000022", rd_data[0 +: DW]);
        end
    endtask

    task automatic test_bypass_timing();
        logic [DW-1:0] e;
        idle();
        set_wr(0, 1'b1, 3, 32'hABCD);
        set_rd(1, 3);
        #2;
        e = exp_rd(3);
        checks++;
        if (rd_data[DW +: DW] !== e) begin
            failures++;
            $display("[TB] FAIL bypass_same_cycle got=%h exp=%h", rd_data[DW +: DW], e);
        end
        tick();
        idle();
        set_rd(1, 3);
        #2;
        checks++;
        if (rd_data[DW +: DW] !== 32'hABCD) begin
            failures++;
            $display("[TB] FAIL bypass_next got=%h exp=0000abcd", rd_data[DW +: DW]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        iss_en = 1'b1;
        iss_addr = 5'd9;
        set_rd(2, 9);
        #2;
        checks++;
        if (rd_busy[2] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sb_no_early_busy got=%b exp=0", rd_busy[2]);
        end
        tick();
        idle();
        set_rd(2, 9);
        #2;
        checks++;
        if (busy_vec[9] !== 1'b1 || rd_busy[2] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sb_set got=%b/%b exp=1/1", busy_vec[9], rd_busy[2]);
        end
        tick();
        tick();
        set_wr(0, 1'b1, 9, 32'h99);
        #2;
        checks++;
        if (busy_vec[9] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sb_hold got=%b exp=1", busy_vec[9]);
        end
        tick();
        idle();
        #2;
        checks++;
        if (busy_vec[9] !== 1'b0 || busy_vec !== exp_busy_vec()) begin
            failures++;
            $display("[TB] FAIL sb_clear got=%h exp=%h", busy_vec, exp_busy_vec());
        end
        iss_en = 1'b1;
        iss_addr = 5'd9;
        set_wr(1, 1'b1, 9, 32'h77);
        tick();
        idle();
        #2;
        checks++;
        if (busy_vec[9] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sb_set_wins got=%b exp=1", busy_vec[9]);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        iss_en = 1'b1;
        iss_addr = 5'd4;
        set_wr(0, 1'b1, 4, 32'h55);
        tick();
        idle();
        iss_en = 1'b1;
        iss_addr = 5'd12;
        tick();
        idle();
        set_rd(0, 4);
        #2;
        checks++;
        if (busy_vec !== exp_busy_vec() || busy_vec[4] !== 1'b1 || busy_vec[12] !== 1'b1 || rd_data[0 +: DW] !== 32'h55) begin
            failures++;
            $display("[TB] FAIL mid_before busy=%h data=%h exp busy=%h data=00000055", busy_vec, rd_data[0 +: DW], exp_busy_vec());
        end
        areset = 1'b1;
        tick();
        idle();
        set_rd(0, 4);
        #2;
        checks++;
        if (busy_vec !== '0 || rd_data[0 +: DW] !== 32'h0) begin
            failures++;
            $display("[TB] FAIL mid_after busy=%h data=%h exp busy=0 data=0", busy_vec, rd_data[0 +: DW]);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] e;
        int a;
        for (int c = 0; c < 400; c++) begin
            idle();
            areset = ($urandom_range(0, 49) == 0);
            for (int w = 0; w < NW; w++) begin
                a = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, RN - 1);
                set_wr(w, 1'($urandom_range(0, 1)), a, $urandom);
            end
            iss_en = 1'($urandom_range(0, 1));
            iss_addr = AW'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, RN - 1));
            for (int p = 0; p < NR; p++) set_rd(p, $urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, RN - 1));
            #2;
            for (int p = 0; p < NR; p++) begin
                a = int'(rd_addr[p*AW +: AW]);
                e = exp_rd(a);
                checks++;
                if (rd_data[p*DW +: DW] !== e) begin
                    failures++;
                    $display("[TB] FAIL rand_rd c%0d port%0d r%0d got=%h exp=%h", c, p, a, rd_data[p*DW +: DW], e);
                end
                checks++;
                if (rd_busy[p] !== (a == 0 ? 1'b0 : m_busy[a])) begin
                    failures++;
                    $display("[TB] FAIL rand_rd_busy c%0d port%0d r%0d got=%b exp=%b", c, p, a, rd_busy[p], (a == 0 ? 1'b0 : m_busy[a]));
                end
            end
            tick();
            checks++;
            if (busy_vec !== exp_busy_vec()) begin
                failures++;
                $display("[TB] FAIL rand_busy_vec c%0d got=%h exp=%h", c, busy_vec, exp_busy_vec());
            end
        end
    endtask

    initial begin
        idle();
        areset = 1'b1;
        @(posedge aclk);
        #1;
        test_reset();
        test_r0();
        test_collision();
        test_bypass_timing();
        test_scoreboard();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
